fft_stage_sequencer: RTL and testbench

//   Sequences the in-place radix-2 DIT FFT core: walks all layers and butterflies, issuing per butterfly
//   the two data-RAM read addresses, the twiddle-ROM address, and the matching delayed write-back

---
 rtl/fft_stage_sequencer.sv | 152 +++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT: walks layers and butterflies, issues
// RAM/ROM read addresses and the BF_LAT-delayed write-back. Optional `FFT_HOLD_EN adds a RUN stall input.
module fft_stage_sequencer #(
    parameter int LOG2N  = 7,
    parameter int BF_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] lay_cnt,
    output logic [LOG2N-2:0] bf_cnt,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_add_a,
    output logic [LOG2N-1:0] rd_add_b,
    output logic [LOG2N-2:0] rom_wn,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_add_a,
    output logic [LOG2N-1:0] wr_add_b
);
    localparam logic [LOG2N-2:0] BF_LAST  = {(LOG2N-1){1'b1}};
    localparam logic [LOG2N-1:0] LAY_LAST = LOG2N'(LOG2N - 1);
    localparam logic [3:0]       DRN_LAST = 4'(BF_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

    state_t              state_q, state_d;
    logic [LOG2N-2:0]    bf_q, bf_d;
    logic [LOG2N-1:0]    lay_q, lay_d;
    logic [3:0]          drn_q, drn_d;
    logic [LOG2N-1:0]    a_q, a_d, b_q, b_d;
    logic [LOG2N-2:0]    wn_q, wn_d;
    logic                run_hold;

    logic [LOG2N-1:0]    k_w, h_w, p_w, g_w;
    int                  l_w;

    logic [BF_LAT-1:0]              dl_en_q;
    logic [BF_LAT-1:0][LOG2N-1:0]   dl_a_q, dl_b_q;

`ifdef FFT_HOLD_EN
    assign run_hold = hold;
`else
    assign run_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bf_q    <= '0;
            lay_q   <= '0;
            drn_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wn_q    <= '0;
        end else begin
            state_q <= state_d;
            bf_q    <= bf_d;
            lay_q   <= lay_d;
            drn_q   <= drn_d;
            // addresses only reload when the next cycle is a read cycle
            if (state_d == S_RUN) begin
                a_q  <= a_d;
                b_q  <= b_d;
                wn_q <= wn_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bf_d    = bf_q;
        lay_d   = lay_q;
        drn_d   = drn_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                bf_d    = '0;
                lay_d   = '0;
            end
            S_RUN: if (!run_hold) begin
                if (bf_q == BF_LAST) begin
                    state_d = S_DRAIN;
                    bf_d    = '0;
                    drn_d   = '0;
                end else begin
                    bf_d = bf_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    if (lay_q == LAY_LAST) begin
                        state_d = S_FINISH;
                        lay_d   = '0;
                    end else begin
                        state_d = S_RUN;
                        lay_d   = lay_q + 1'b1;
                    end
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // h=2^L, g=k>>L, p=k&(h-1): a=g*2h+p, b=a+h, wn=p<<(LOG2N-1-L)
    always_comb begin
        l_w  = int'(lay_d);
        k_w  = {1'b0, bf_d};
        h_w  = LOG2N'(1) << l_w;
        p_w  = k_w & (h_w - LOG2N'(1));
        g_w  = k_w >> l_w;
        a_d  = (g_w << (l_w + 1)) | p_w;
        b_d  = a_d | h_w;
        wn_d = p_w[LOG2N-2:0] << (LOG2N - 1 - l_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_en_q <= '0;
            dl_a_q  <= '0;
            dl_b_q  <= '0;
        end else begin
            dl_en_q[0] <= rd_en;
            dl_a_q[0]  <= a_q;
            dl_b_q[0]  <= b_q;
            for (int i = BF_LAT - 1; i > 0; i--) begin
                dl_en_q[i] <= dl_en_q[i-1];
                dl_a_q[i]  <= dl_a_q[i-1];
                dl_b_q[i]  <= dl_b_q[i-1];
            end
        end
    end

    assign rd_en    = (state_q == S_RUN) && !run_hold;
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_FINISH);
    assign lay_cnt  = lay_q;
    assign bf_cnt   = bf_q;
    assign rd_add_a = a_q;
    assign rd_add_b = b_q;
    assign rom_wn   = wn_q;
    assign wr_en    = dl_en_q[BF_LAT-1];
    assign wr_add_a = dl_a_q[BF_LAT-1];
    assign wr_add_b = dl_b_q[BF_LAT-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at default parameters (LOG2N=7, BF_LAT=4).
module tb_fft_stage_sequencer;
    localparam int LOG2N = 7;
    localparam int NBF   = 64;
    localparam int LAT   = 4;
    localparam int LSPAN = NBF + LAT;          // cycles per layer
    localparam int LAST_BUSY = LOG2N * LSPAN;  // 476; done at 477

    logic       clk = 0, rst = 1, start = 0;
`ifdef FFT_HOLD_EN
    logic       hold = 0;
`endif
    logic       busy, done, rd_en, wr_en;
    logic [6:0] lay_cnt, rd_add_a, rd_add_b, wr_add_a, wr_add_b;
    logic [5:0] bf_cnt, rom_wn;

    fft_stage_sequencer #(.LOG2N(LOG2N), .BF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT_HOLD_EN
        .hold(hold),
`endif
        .busy(busy), .done(done), .lay_cnt(lay_cnt), .bf_cnt(bf_cnt),
        .rd_en(rd_en), .rd_add_a(rd_add_a), .rd_add_b(rd_add_b), .rom_wn(rom_wn),
        .wr_en(wr_en), .wr_add_a(wr_add_a), .wr_add_b(wr_add_b)
    );

    always #5 clk = ~clk;

    typedef struct { int lay; int k; int a; int b; int wn; } vec_t;
    vec_t vecs[12];

    int checks = 0, errors = 0;
    int rd_cnt, wr_cnt, done_cnt, done_cyc, tim_err, wr_err, busy_err, cov_err;
    int rec_a[7][64], rec_b[7][64], rec_wn[7][64];
    int cov[7][128];
    int hist_en[700], hist_a[700], hist_b[700];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Watches ncyc cycles; cycle 1 is the one after the edge that sampled start.
    task automatic observe(input int ncyc, input bit keep_start);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        tim_err = 0; wr_err = 0; busy_err = 0; cov_err = 0;
        for (int l = 0; l < 7; l++) begin
            for (int k = 0; k < 64; k++) begin
                rec_a[l][k] = -1; rec_b[l][k] = -1; rec_wn[l][k] = -1;
            end
            for (int x = 0; x < 128; x++) cov[l][x] = 0;
        end
        for (int i = 1; i <= ncyc; i++) begin
            bit exp_rd, exp_wr, exp_busy;
            @(negedge clk);
            if (!keep_start || done_cnt > 0) start = 0;
            exp_rd   = (i <= LAST_BUSY) && (((i - 1) % LSPAN) < NBF);
            exp_busy = (i <= LAST_BUSY);
            if (rd_en !== exp_rd) tim_err++;
            if (busy !== exp_busy) busy_err++;
            if (rd_en) begin
                rd_cnt++;
                if (int'(lay_cnt) != (i - 1) / LSPAN || int'(bf_cnt) != (i - 1) % LSPAN) tim_err++;
                else begin
                    rec_a[lay_cnt][bf_cnt]  = int'(rd_add_a);
                    rec_b[lay_cnt][bf_cnt]  = int'(rd_add_b);
                    rec_wn[lay_cnt][bf_cnt] = int'(rom_wn);
                    cov[lay_cnt][rd_add_a]++;
                    cov[lay_cnt][rd_add_b]++;
                end
            end
            hist_en[i] = int'(rd_en); hist_a[i] = int'(rd_add_a); hist_b[i] = int'(rd_add_b);
            exp_wr = (i > LAT) ? hist_en[i-LAT][0] : 1'b0;
            if (wr_en !== exp_wr) wr_err++;
            else if (wr_en && (int'(wr_add_a) != hist_a[i-LAT] || int'(wr_add_b) != hist_b[i-LAT])) wr_err++;
            if (wr_en) wr_cnt++;
            if (done) begin done_cnt++; done_cyc = i; end
        end
        for (int l = 0; l < 7; l++)
            for (int x = 0; x < 128; x++)
                if (cov[l][x] != 1) cov_err++;
    endtask

    initial begin
        vecs[0]  = '{0,  5,  10,  11,  0};
        vecs[1]  = '{2,  5,   9,  13, 16};
        vecs[2]  = '{6, 37,  37, 101, 37};
        vecs[3]  = '{0,  0,   0,   1,  0};
        vecs[4]  = '{0, 63, 126, 127,  0};
        vecs[5]  = '{1,  3,   5,   7, 32};
        vecs[6]  = '{3, 10,  18,  26, 16};
        vecs[7]  = '{5, 40,  72, 104, 16};
        vecs[8]  = '{6,  0,   0,  64,  0};
        vecs[9]  = '{6, 63,  63, 127, 63};
        vecs[10] = '{4, 31,  47,  63, 60};
        vecs[11] = '{2, 63, 123, 127, 48};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, done, rd_en, wr_en}, 0);
        chk("rst_cnt", {lay_cnt, bf_cnt}, 0);
        chk("rst_rd_addr", {rd_add_a, rd_add_b, rom_wn}, 0);
        chk("rst_wr_addr", {wr_add_a, wr_add_b}, 0);
        rst = 0;

        // reset in the middle of layer 3 aborts with no done
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int w = 0; w < 400 && lay_cnt != 3; w++) @(negedge clk);
        chk("midrun_reach_l3", lay_cnt, 3);
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        chk("midrun_rst_out", {busy, done, rd_en, wr_en, lay_cnt, bf_cnt, rd_add_a, rd_add_b,
                               rom_wn, wr_add_a, wr_add_b}, 0);
        @(negedge clk); rst = 0;
        done_cnt = 0; busy_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy || rd_en || wr_en) busy_err++;
        end
        chk("midrun_no_done", done_cnt, 0);
        chk("midrun_idle", busy_err, 0);

        // full transform from a single start pulse
        @(negedge clk); start = 1;
        observe(520, 1'b0);
        chk("full_rd_cnt", rd_cnt, 448);
        chk("full_wr_cnt", wr_cnt, 448);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_done_cyc", done_cyc, 477);
        chk("full_rd_timing", tim_err, 0);
        chk("full_wr_delay", wr_err, 0);
        chk("full_busy", busy_err, 0);
        chk("full_addr_cover", cov_err, 0);
        for (int v = 0; v < 12; v++) begin
            chk($sformatf("vec%0d_L%0d_k%0d_a", v, vecs[v].lay, vecs[v].k),
                rec_a[vecs[v].lay][vecs[v].k], vecs[v].a);
            chk($sformatf("vec%0d_L%0d_k%0d_b", v, vecs[v].lay, vecs[v].k),
                rec_b[vecs[v].lay][vecs[v].k], vecs[v].b);
            chk($sformatf("vec%0d_L%0d_k%0d_wn", v, vecs[v].lay, vecs[v].k),
                rec_wn[vecs[v].lay][vecs[v].k], vecs[v].wn);
        end

        // start held through the transform and the done cycle: only one transform
        @(negedge clk); start = 1;
        observe(540, 1'b1);
        start = 0;
        chk("hold_start_done_cnt", done_cnt, 1);
        chk("hold_start_done_cyc", done_cyc, 477);
        chk("hold_start_rd_cnt", rd_cnt, 448);
        chk("hold_start_timing", tim_err, 0);
        chk("hold_start_idle_end", {busy, rd_en}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
